// File: rtl/pixel_peak_detect_if.sv
// Sensor pixel bus for the peak detector.
// Inputs to the detector: frame_start, pdata1, pdata2.
// Outputs from the detector: per-channel peak value/index and frame sum,
// plus result_valid / frame_abort pulses and busy.
// The master modport is the sensor/consumer side; slave is the detector.
interface pixel_peak_detect_if #(
  parameter int unsigned PIXELS = 128,
  parameter int unsigned DW     = 12
);
  localparam int unsigned IW = $clog2(PIXELS);
  localparam int unsigned SW = DW + IW;

  logic          frame_start;
  logic [DW-1:0] pdata1;
  logic [DW-1:0] pdata2;
  logic [DW-1:0] peak_val1;
  logic [DW-1:0] peak_val2;
  logic [IW-1:0] peak_idx1;
  logic [IW-1:0] peak_idx2;
  logic [SW-1:0] sum1;
  logic [SW-1:0] sum2;
  logic          result_valid;
  logic          frame_abort;
  logic          busy;

  modport master (
    output frame_start, pdata1, pdata2,
    input  peak_val1, peak_val2, peak_idx1, peak_idx2, sum1, sum2,
    input  result_valid, frame_abort, busy
  );

  modport slave (
    input  frame_start, pdata1, pdata2,
    output peak_val1, peak_val2, peak_idx1, peak_idx2, sum1, sum2,
    output result_valid, frame_abort, busy
  );
endinterface

// File: rtl/pixel_peak_detect.sv
// Two-channel per-frame peak/index/sum detector for a parallel-ADC line sensor.
// Ports: sensor_clk (one pixel per rising edge), reset (async, active-high),
// bus (pixel_peak_detect_if.slave): frame_start/pdata in, results and
// result_valid / frame_abort / busy out. After frame_start, SKIP cycles are
// discarded, then PIXELS samples per channel are accumulated; the result
// registers update on the last-pixel edge and hold until the next frame.
module pixel_peak_detect #(
  parameter int unsigned PIXELS = 128,
  parameter int unsigned SKIP   = 2,
  parameter int unsigned DW     = 12
) (
  input  logic                 sensor_clk,
  input  logic                 reset,
  pixel_peak_detect_if.slave   bus
);
  localparam int unsigned IW = $clog2(PIXELS);
  localparam int unsigned SW = DW + IW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SKIP = 2'd1;
  localparam logic [1:0] ST_ACQ  = 2'd2;

  localparam logic [3:0]    SKIP_LOAD = (SKIP == 0) ? 4'd0 : 4'(SKIP - 1);
  localparam logic [IW-1:0] LAST_PIX  = IW'(PIXELS - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    skip_q, skip_d;
  logic [IW-1:0] pix_q, pix_d;
  logic [DW-1:0] max1_q, max1_d, max2_q, max2_d;
  logic [IW-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
  logic [SW-1:0] sum1_q, sum1_d, sum2_q, sum2_d;
  logic [DW-1:0] pv1_q, pv1_d, pv2_q, pv2_d;
  logic [IW-1:0] pi1_q, pi1_d, pi2_q, pi2_d;
  logic [SW-1:0] ps1_q, ps1_d, ps2_q, ps2_d;
  logic          rv_q, rv_d, abort_q, abort_d, busy_q, busy_d;
  logic          restart;

  // Running values including the current sample; pixel 0 seeds them.
  logic          first_pix;
  logic          gt1, gt2;
  logic [DW-1:0] fin_max1, fin_max2;
  logic [IW-1:0] fin_idx1, fin_idx2;
  logic [SW-1:0] fin_sum1, fin_sum2;

  assign first_pix = (pix_q == '0);
  assign gt1       = (bus.pdata1 > max1_q);
  assign gt2       = (bus.pdata2 > max2_q);
  assign fin_max1  = (first_pix || gt1) ? bus.pdata1 : max1_q;
  assign fin_max2  = (first_pix || gt2) ? bus.pdata2 : max2_q;
  assign fin_idx1  = first_pix ? '0 : (gt1 ? pix_q : idx1_q);
  assign fin_idx2  = first_pix ? '0 : (gt2 ? pix_q : idx2_q);
  assign fin_sum1  = first_pix ? SW'(bus.pdata1) : sum1_q + SW'(bus.pdata1);
  assign fin_sum2  = first_pix ? SW'(bus.pdata2) : sum2_q + SW'(bus.pdata2);

  // Next-state and register-input logic.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    pix_d   = pix_q;
    max1_d  = max1_q;
    max2_d  = max2_q;
    idx1_d  = idx1_q;
    idx2_d  = idx2_q;
    sum1_d  = sum1_q;
    sum2_d  = sum2_q;
    pv1_d   = pv1_q;
    pv2_d   = pv2_q;
    pi1_d   = pi1_q;
    pi2_d   = pi2_q;
    ps1_d   = ps1_q;
    ps2_d   = ps2_q;
    rv_d    = 1'b0;
    abort_d = 1'b0;
    restart = 1'b0;

    case (state_q)
      ST_IDLE: restart = bus.frame_start;
      ST_SKIP: begin
        if (bus.frame_start) begin
          abort_d = 1'b1;
          restart = 1'b1;
        end else if (skip_q == 4'd0) begin
          state_d = ST_ACQ;
          pix_d   = '0;
        end else begin
          skip_d = skip_q - 4'd1;
        end
      end
      ST_ACQ: begin
        // A start on the last pixel completes the frame instead of aborting.
        if (bus.frame_start && (pix_q != LAST_PIX)) begin
          abort_d = 1'b1;
          restart = 1'b1;
        end else begin
          max1_d = fin_max1;
          max2_d = fin_max2;
          idx1_d = fin_idx1;
          idx2_d = fin_idx2;
          sum1_d = fin_sum1;
          sum2_d = fin_sum2;
          pix_d  = pix_q + IW'(1);
          if (pix_q == LAST_PIX) begin
            pv1_d   = fin_max1;
            pv2_d   = fin_max2;
            pi1_d   = fin_idx1;
            pi2_d   = fin_idx2;
            ps1_d   = fin_sum1;
            ps2_d   = fin_sum2;
            rv_d    = 1'b1;
            state_d = ST_IDLE;
            restart = bus.frame_start;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      if (SKIP == 0) begin
        state_d = ST_ACQ;
        pix_d   = '0;
      end else begin
        state_d = ST_SKIP;
        skip_d  = SKIP_LOAD;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and result registers.
  always_ff @(posedge sensor_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      pix_q   <= '0;
      max1_q  <= '0;
      max2_q  <= '0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      sum1_q  <= '0;
      sum2_q  <= '0;
      pv1_q   <= '0;
      pv2_q   <= '0;
      pi1_q   <= '0;
      pi2_q   <= '0;
      ps1_q   <= '0;
      ps2_q   <= '0;
      rv_q    <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      pix_q   <= pix_d;
      max1_q  <= max1_d;
      max2_q  <= max2_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      sum1_q  <= sum1_d;
      sum2_q  <= sum2_d;
      pv1_q   <= pv1_d;
      pv2_q   <= pv2_d;
      pi1_q   <= pi1_d;
      pi2_q   <= pi2_d;
      ps1_q   <= ps1_d;
      ps2_q   <= ps2_d;
      rv_q    <= rv_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.peak_val1    = pv1_q;
  assign bus.peak_val2    = pv2_q;
  assign bus.peak_idx1    = pi1_q;
  assign bus.peak_idx2    = pi2_q;
  assign bus.sum1         = ps1_q;
  assign bus.sum2         = ps2_q;
  assign bus.result_valid = rv_q;
  assign bus.frame_abort  = abort_q;
  assign bus.busy         = busy_q;
endmodule

// File: doc/pixel_peak_detect.md
PIXEL_PEAK_DETECT -- requirements
Module: pixel_peak_detect

Interface
REQ-001 Parameter PIXELS, default 128: pixels per sensor frame; power of two, 2..256.
REQ-002 Parameter SKIP, default 2: sensor_clk cycles discarded after frame_start (ADC pipeline alignment); range 0..15.
REQ-003 Parameter DW, default 12: sample width.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 sensor_clk  input  1  clock sensor_clk; one pixel per rising edge.
REQ-006 frame_start  input  1  single-cycle frame start, aligned with the ADC sampling request.
REQ-007 pdata1  input  DW  channel-1 parallel ADC sample.
REQ-008 pdata2  input  DW  channel-2 parallel ADC sample.
REQ-009 peak_val1, peak_val2  output  DW each  maximum sample of the last completed frame.
REQ-010 peak_idx1, peak_idx2  output  log2(PIXELS) each  pixel index of that maximum.
REQ-011 sum1, sum2  output  DW+log2(PIXELS) each  sum of all samples of the last completed frame (19 bits at defaults).
REQ-012 result_valid  output  1  one-cycle pulse when the result outputs update.
REQ-013 frame_abort  output  1  one-cycle pulse when an in-progress frame is discarded.
REQ-014 busy  output  1  high in SKIP or ACQ state.

Function
REQ-015 FSM states SHALL be IDLE, SKIP, ACQ; encoding is free.
REQ-016 IDLE: frame_start SHALL go to SKIP with skip counter = SKIP-1, or straight to ACQ with pixel counter 0 when SKIP=0.
REQ-017 SKIP: samples SHALL be ignored; the counter decrements each edge; at 0 the FSM enters ACQ with pixel counter 0.
REQ-018 ACQ: each edge samples one pixel per channel, increments the pixel counter, adds the sample to the running sum, and updates the running max/index.
REQ-019 Max update only when the sample is strictly greater than the running max, so on ties the lowest index wins; the running max starts at 0, index 0.
REQ-020 Pixel 0 in ACQ SHALL initialise the running max, index and sum from the sample itself rather than accumulating stale values.
REQ-021 Sum arithmetic SHALL be unsigned and full-width; it cannot overflow (PIXELS*(2^DW-1) fits).
REQ-022 On the edge sampling pixel PIXELS-1, the final max/index/sum, including that pixel, SHALL be loaded into the output registers, and the FSM returns to IDLE.
REQ-023 result_valid SHALL be high for exactly the cycle following that edge; latency from the frame_start edge to the result_valid assertion = SKIP+PIXELS edges.
REQ-024 Outputs SHALL hold their values between result_valid pulses.
REQ-025 frame_start while in SKIP or ACQ SHALL abort: frame_abort pulses the next cycle, running values are discarded, output registers are untouched, and the new frame restarts per REQ-016.
REQ-026 frame_start coincident with the last-pixel edge SHALL complete the frame (result_valid pulses) and also start a new frame; frame_abort stays low.
REQ-027 busy SHALL be registered state decode, not combinational from frame_start.

Reset
REQ-028 Reset asserted SHALL immediately force IDLE and clear all counters, running values and outputs to 0; result_valid, frame_abort and busy are 0.
REQ-029 Reset mid-frame SHALL discard the frame without a result_valid or frame_abort pulse; the first frame_start after deassertion behaves per REQ-016.

Verification
REQ-030 Ramp: defaults, pdata1=10*pixel, pdata2=100 constant -> after 130 edges result_valid=1 for 1 cycle; peak_idx1=127, peak_val1=1270, sum1=81280; peak_idx2=0, peak_val2=100, sum2=12800.
REQ-031 Full scale: pdata1=pdata2=4095 for all pixels -> sum1=sum2=524160, peak_val=4095, peak_idx=0.
REQ-032 Spike: pdata1=5 except pixel 64=3000 and pixel 100=3000 -> peak_idx1=64, peak_val1=3000, sum1=5*126+6000=6630.
REQ-033 Abort: frame_start again at pixel 50 -> frame_abort pulses once; no result_valid; the previous results stay held; result_valid arrives 130 edges after the second frame_start.
REQ-034 Reset during ACQ at pixel 30 -> all outputs 0 immediately; busy=0; no pulses; the next frame completes normally.
REQ-035 SKIP=0, PIXELS=4, samples 7,9,9,2 -> result_valid after 4 edges; peak_idx=1, peak_val=9, sum=27.
